writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port 3 arbiter between ALU results and load responses
//
// Each cycle this block picks one writer for register-file write port 3. The ALU
// always wins. Load responses are queued in a 2-entry FIFO and use any cycle the
// ALU leaves free. The block also tracks which registers have loads in flight, and
// asks upstream for an ALU bubble when queued loads have been blocked too long.
//
// Parameters:
//   STARVE_LIMIT  consecutive blocked edges before stall_alu asserts
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU result; no backpressure, always taken
//   mem_valid/mem_ready             load response handshake
//   mem_rd/mem_data                 load response destination and data
//   issue_valid/issue_rd            load issue notice; marks rd as pending
//   write_en_3/addr_3/data_3        registered register-file write port
//   pending_mask                    one bit per register with a load outstanding
//   stall_alu                       request for a one-cycle ALU bubble
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        write_en_3,
  output logic [4:0]  write_addr_3,
  output logic [31:0] write_data_3,
  output logic [31:0] pending_mask,
  output logic        stall_alu
);

  // Counter must be able to hold STARVE_LIMIT itself.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Load response FIFO: two slots addressed by a 1-bit head pointer.
  logic [4:0]    fifo_rd   [2];
  logic [31:0]   fifo_data [2];
  logic [1:0]    count;
  logic          head;
  logic          tail;

  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic [1:0]    count_nxt;

  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;

  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [31:0]   pending_nxt;

  // Ready depends only on the registered count, so no combinational path from
  // mem_valid or alu_valid reaches mem_ready.
  assign mem_ready     = (count < 2'd2);
  assign fifo_nonempty = (count != 2'd0);
  assign push          = mem_valid & mem_ready;
  // The FIFO only drains when the ALU leaves the port free.
  assign pop           = ~alu_valid & fifo_nonempty;
  // With count 0 the tail is the head slot; with count 1 it is the other slot.
  // Count 2 never pushes, so its tail value is irrelevant.
  assign tail          = head ^ count[0];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Source selection: ALU first, otherwise the FIFO head (never a same-edge push).
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (fifo_nonempty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[head];
      sel_data  = fifo_data[head];
    end
  end

  // Starvation: counts edges where a queued load is blocked by the ALU.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || !fifo_nonempty) begin
      starve_nxt = '0;
    end else if (alu_valid && (starve_cnt != LIMIT)) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  assign stall_alu = (starve_cnt == LIMIT);

  // A new issue to the same register wins over the retiring load's clear,
  // since that issue starts a fresh outstanding load. Register 0 never pends.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_valid) begin
      set_mask = 32'd1 << issue_rd;
    end
    if (pop) begin
      clr_mask = 32'd1 << fifo_rd[head];
    end
    pending_nxt = ((pending_mask & ~clr_mask) | set_mask) & ~32'd1;
  end

  // FIFO storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= mem_rd;
      fifo_data[tail] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 2'd0;
      head         <= 1'b0;
      starve_cnt   <= '0;
      pending_mask <= 32'd0;
      write_en_3   <= 1'b0;
      write_addr_3 <= 5'd0;
      write_data_3 <= 32'd0;
    end else begin
      count        <= count_nxt;
      starve_cnt   <= starve_nxt;
      pending_mask <= pending_nxt;
      if (pop) begin
        head <= ~head;
      end
      // rd=0 is consumed like any other source but never writes.
      write_en_3 <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        write_addr_3 <= sel_rd;
        write_data_3 <= sel_data;
      end
    end
  end

endmodule
